mc_main_ctrl: RTL
=================

Name: mc_main_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences instruction fetch, decode, execute, memory access and writeback by driving the datapath selects and enables: ALU operand selects, PC source, register-file and IR enables. The ALU operand-A mux select comes from here. It sits between the instruction register opcode field, the ALU zero flag and the memory ready handshake.

Parameters:
- OPW, 6, opcode width.
- SW, 4, state encoding width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPW  IR[31:26].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write (valid with mem_req).
- i_or_d  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  IR load enable.
- pc_write  out  1  effective PC enable, already OR'd with the branch condition.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_src_a  out  1  ALU operand A: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU operand B: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op  out  2  ALU operation class: 00 = add, 01 = subtract, 10 = funct, 11 = or-immediate.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback data: 0 = ALUOut, 1 = MDR.
- illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded.
- state_o  out  SW  current state, for debug.

Behaviour:
- Reset:
  - Asynchronous; state goes to IDLE (0).
  - In IDLE every output is 0.
  - IDLE moves to FETCH on the first clock edge after rst_n deasserts.
- Default outputs:
  - Every output not listed for a state is 0.
  - Outputs are Moore, decoded from the state register, except the write enables gated by mem_ready or zero, as noted below.
- FETCH:
  - mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write=pc_write=mem_ready.
  - Stay in FETCH while mem_ready=0. Go to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target computed into ALUOut).
  - Next state by opcode:
    - LW 0x23 or SW 0x2B -> MEMADR
    - R-type 0x00 -> EXEC
    - BEQ 0x04 -> BEQ
    - ADDI 0x08 or ORI 0x0D -> IEXEC
    - J 0x02 -> JUMP
    - any other opcode -> FETCH, with illegal_op=1 for this cycle.
- MEMADR:
  - alu_src_a=1, alu_src_b=10, alu_op=00.
  - LW -> MEMRD, SW -> MEMWR.
- MEMRD:
  - mem_req=1, i_or_d=1.
  - Hold until mem_ready=1, then go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
- MEMWR:
  - mem_req=1, mem_we=1, i_or_d=1.
  - Hold until mem_ready=1, then go to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- BEQ:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_write=zero.
  - Go to FETCH.
- IEXEC:
  - alu_src_a=1, alu_src_b=10.
  - alu_op=00 for ADDI, 11 for ORI.
  - Go to IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
- JUMP: pc_src=10, pc_write=1. Go to FETCH.
- Opcode usage: opcode is sampled combinationally in DECODE, MEMADR and IEXEC. The IR is stable there because ir_write=0 outside FETCH.
- Reset mid-operation: all outputs go to 0 immediately, including during a stalled memory access. The requester must drop any access that is in flight.
- Illegal state encodings go to IDLE on the next clock.
- Latency in cycles with zero memory wait:
  - LW 5, SW 4, R-type 4, ADDI/ORI 4, BEQ 3, J 3.
  - Each memory wait cycle adds 1.

Decomposition:
- Package mc_pkg:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J);
  - state enum (IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BEQ, IEXEC, IWB, JUMP);
  - alu_op, alu_src_b and pc_src encodings.
- Sub-module mc_ctrl_decode: purely combinational state-to-control-word decode.
- Top module: state register, next-state logic, and the mem_ready/zero gating.

Test Plan:
- Reset, then release, opcode=0x00, mem_ready=1 every cycle:
  - state sequence IDLE, FETCH, DECODE, EXEC, ALUWB, FETCH.
  - In EXEC, alu_src_a=1 and alu_op=10. In ALUWB, reg_write=1 and reg_dst=1.
- LW (0x23) with mem_ready held 0 for 2 cycles in both FETCH and MEMRD:
  - FETCH lasts 3 cycles; ir_write pulses only in the last one.
  - MEMRD lasts 3 cycles, then MEMWB with mem_to_reg=1.
  - Total 9 cycles.
- BEQ (0x04), run once with zero=1 and once with zero=0:
  - In the BEQ state, pc_write is 1 and 0 respectively, with pc_src=01.
  - In DECODE, alu_src_b=11.
- ORI (0x0D) then J (0x02):
  - In IEXEC, alu_op=11 and alu_src_b=10.
  - In JUMP, pc_src=10 and pc_write=1.
- Opcode 0x3F in DECODE: illegal_op pulses for 1 cycle, next state FETCH, reg_write never asserted.
- SW (0x2B) with rst_n asserted while stalled in MEMWR:
  - mem_req and mem_we drop to 0 in the same cycle, state_o=0.
  - After release, FETCH is entered one cycle later.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM:
// opcode constants, FSM state enum, control-field encodings and the
// control word produced by the state decoder.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BEQ    = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11,
    JUMP   = 4'd12
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_ORI   = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_e;

  // Ungated control word; the *_rdy / *_zero enables are qualified by
  // mem_ready / zero in the top level.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write_rdy;
    logic       pc_write_rdy;
    logic       pc_write_uncond;
    logic       pc_write_zero;
    pc_src_e    pc_src;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-control-word decode for mc_main_ctrl.
//   state  : current FSM state
//   is_ori : IR opcode is ORI (selects the ALU class in IEXEC)
//   cw     : control word, all-zero for IDLE and unused encodings
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_e state,
  input  logic   is_ori,
  output ctrl_t  cw
);

  always_comb begin
    cw = '0;
    case (state)
      FETCH: begin
        cw.mem_req      = 1'b1;
        cw.alu_src_b    = SRCB_FOUR;
        cw.ir_write_rdy = 1'b1;
        cw.pc_write_rdy = 1'b1;
      end
      DECODE: cw.alu_src_b = SRCB_IMM_SH2;
      MEMADR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        cw.mem_req = 1'b1;
        cw.i_or_d  = 1'b1;
      end
      MEMWB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        cw.mem_req = 1'b1;
        cw.mem_we  = 1'b1;
        cw.i_or_d  = 1'b1;
      end
      EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = 1'b1;
      end
      BEQ: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_op        = ALU_SUB;
        cw.pc_src        = PCSRC_ALUOUT;
        cw.pc_write_zero = 1'b1;
      end
      IEXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = is_ori ? ALU_ORI : ALU_ADD;
      end
      IWB: cw.reg_write = 1'b1;
      JUMP: begin
        cw.pc_src          = PCSRC_JUMP;
        cw.pc_write_uncond = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Inputs : clk, rst_n (async, active low), opcode (IR[31:26]),
//          zero (ALU zero flag), mem_ready (memory completes this cycle).
// Outputs: memory request/write/address select, IR and PC enables,
//          PC source, ALU operand/operation selects, register-file
//          write controls, illegal_op pulse and state_o debug view.
module mc_main_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned OPW = 6,
  parameter int unsigned SW  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_we,
  output logic           i_or_d,
  output logic           ir_write,
  output logic           pc_write,
  output logic [1:0]     pc_src,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic           reg_write,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           illegal_op,
  output logic [SW-1:0]  state_o
);

  state_e     state_q, state_d;
  logic [5:0] op;
  logic       illegal;
  ctrl_t      cw;

  assign op = 6'(opcode);

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:    state_d = MEMADR;
          OP_RTYPE:        state_d = EXEC;
          OP_BEQ:          state_d = BEQ;
          OP_ADDI, OP_ORI: state_d = IEXEC;
          OP_J:            state_d = JUMP;
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (mem_ready) state_d = FETCH;
      EXEC:   state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      BEQ:    state_d = FETCH;
      IEXEC:  state_d = IWB;
      IWB:    state_d = FETCH;
      JUMP:   state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  mc_ctrl_decode u_decode (
    .state  (state_q),
    .is_ori (op == OP_ORI),
    .cw     (cw)
  );

  assign mem_req    = cw.mem_req;
  assign mem_we     = cw.mem_we;
  assign i_or_d     = cw.i_or_d;
  assign ir_write   = cw.ir_write_rdy & mem_ready;
  assign pc_write   = cw.pc_write_uncond
                    | (cw.pc_write_rdy & mem_ready)
                    | (cw.pc_write_zero & zero);
  assign pc_src     = cw.pc_src;
  assign alu_src_a  = cw.alu_src_a;
  assign alu_src_b  = cw.alu_src_b;
  assign alu_op     = cw.alu_op;
  assign reg_write  = cw.reg_write;
  assign reg_dst    = cw.reg_dst;
  assign mem_to_reg = cw.mem_to_reg;
  assign illegal_op = illegal;
  assign state_o    = SW'(state_q);

endmodule
